// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int IFU_XLEN    = 32;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [IFU_XLEN-1:0] instr;
        logic [IFU_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order sync FIFO with flush, used for prefetch and in-flight PCs
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter type entry_t  = fetch_entry_t,
    parameter int  DEPTH    = 4,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    input  logic          flush,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = CW - 1;

    entry_t        mem [DEPTH];
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + CW'(1);
            if (pop)  rptr <= rptr + CW'(1);
        end
    end

    // A push into a full FIFO with a same-cycle pop lands in the slot being read out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, credit-limited fetch issue and prefetch buffer
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         pf_count;
    logic [CW-1:0]         outstanding;
    logic [CW:0]           credit_used;
    logic                  pf_full;
    logic                  pf_empty;
    logic                  aq_full;
    logic                  aq_empty;
    entry_t                pf_wdata;
    entry_t                pf_head;
    logic [ADDR_WIDTH-1:0] aq_head;
    logic                  req_fire;
    logic                  resp_keep;
    logic                  pop;
    logic                  unused_redirect_bits;

    assign credit_used    = {1'b0, pf_count} + {1'b0, outstanding};
    assign imem_req_valid = (state == RUN) && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = !pf_empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_instr = pf_empty ? '0 : pf_head.instr;
    assign out_pc    = pf_empty ? '0 : pf_head.pc;

    // Responses that belong to fetches issued before a redirect are discarded.
    assign resp_keep = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign pf_wdata  = {imem_resp_data, aq_head};

    assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_prefetch (
        .clk   (clk),
        .reset (reset),
        .push  (resp_keep),
        .wdata (pf_wdata),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (pf_head),
        .full  (pf_full),
        .empty (pf_empty),
        .count (pf_count)
    );

    // Every accepted request leaves its PC here until its response returns.
    fetch_fifo #(
        .entry_t (logic [ADDR_WIDTH-1:0]),
        .DEPTH   (FIFO_DEPTH)
    ) u_inflight (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .wdata (pc),
        .pop   (imem_resp_valid),
        .flush (1'b0),
        .rdata (aq_head),
        .full  (aq_full),
        .empty (aq_empty),
        .count (outstanding)
    );

    always_comb begin
        state_next = state;
        case (state)
            HALT:    if (fetch_en)  state_next = RUN;
            RUN:     if (!fetch_en) state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HALT;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) pc <= pc + ADDR_WIDTH'(INSTR_BYTES);
                if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == RUN) && pf_empty && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    a_resp_fits: assert property (@(posedge clk) disable iff (reset)
        (imem_resp_valid && !redirect_valid && (drop_cnt == '0)) |-> (!pf_full || pop));
    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> !aq_empty);
    a_req_tracked: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> !aq_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int          checks;
    int          failures;
    int          cyc;
    int          lat;
    int          delivered;
    int          accepted;
    int          base;
    logic [31:0] sb [$];
    mreq_t       mq [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    // One clock: sample handshakes at negedge, then drive the memory response for the next cycle.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            delivered++;
            e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
            check("out_pc", out_pc, e);
            check("out_instr", out_instr, word(e));
        end
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            accepted++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_pc"}, out_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
        check({tag, "_perf_stall"}, perf_stall_cnt, 32'h0);
        check({tag, "_perf_flush"}, perf_flush_cnt, 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        reset           = 1'b1;
        fetch_en        = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        mq.delete();
        sb.delete();
        delivered = 0;
        accepted  = 0;
        @(posedge clk);
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_until_delivered(input int n, input int budget, input string tag);
        int b = budget;
        while (delivered < n && b > 0) begin
            tick();
            b--;
        end
        check(tag, 32'(delivered), 32'(n));
    endtask

    task automatic wait_mq(input int n, input int budget, input string tag);
        int b = budget;
        while (mq.size() != n && b > 0) begin
            tick();
            b--;
        end
        check(tag, 32'(mq.size()), 32'(n));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        cyc            = 0;
        lat            = 1;
        imem_req_ready = 1'b1;

        // Straight-line fetch, latency 1: one instruction per cycle once started.
        do_reset("rst");
        fetch_en = 1'b1;
        out_ready = 1'b1;
        expect_stream(RESET_PC, 64);
        run_until_delivered(1, 20, "sl_first_out");
        base = delivered;
        repeat (8) tick();
        check("sl_throughput", 32'(delivered), 32'(base + 8));

        // Backpressure: four credits then stall; drain in order and resume at 0x10.
        do_reset("rst_bp");
        fetch_en = 1'b1;
        expect_stream(RESET_PC, 64);
        repeat (10) tick();
        check("bp_req_count", 32'(accepted), 32'd4);
        check("bp_req_stalled", 32'(imem_req_valid), 32'h0);
        check("bp_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_resume_valid", 32'(imem_req_valid), 32'h1);
        check("bp_resume_addr", imem_req_addr, 32'h10);
        repeat (12) tick();
        check("bp_drained", 32'(delivered), 32'd13);

        // Redirect with two fetches in flight, latency 3.
        do_reset("rst_rd");
        lat = 3;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        expect_stream(RESET_PC, 64);
        wait_mq(2, 20, "rd_two_inflight");
        sb.delete();
        expect_stream(32'h100, 64);
        redirect_pc = 32'h100;
        redirect_valid = 1'b1;
        #1;
        check("rd_no_req", 32'(imem_req_valid), 32'h0);
        check("rd_no_out", 32'(out_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rd_addr", imem_req_addr, 32'h100);
`ifdef IFU_PERF_CNT_EN
        check("perf_flush_one", perf_flush_cnt, 32'h1);
`endif
        run_until_delivered(3, 40, "rd_out");

        // Misaligned redirect is word-aligned.
        base = delivered;
        sb.delete();
        expect_stream(32'h100, 64);
        redirect_pc = 32'h102;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mis_addr", imem_req_addr, 32'h100);
        run_until_delivered(base + 3, 40, "mis_out");

        // Back-to-back redirects, last one wins, and the PC wraps past the top.
        base = delivered;
        sb.delete();
        expect_stream(32'hFFFF_FFF8, 64);
        redirect_pc = 32'h200;
        redirect_valid = 1'b1;
        tick();
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFF8);
        run_until_delivered(base + 4, 40, "wrap_out");

        // HALT with fetches in flight: both delivered, nothing new issued.
        do_reset("rst_halt");
        lat = 3;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        expect_stream(RESET_PC, 64);
        wait_mq(1, 20, "halt_first_inflight");
        fetch_en = 1'b0;
        repeat (12) tick();
        check("halt_accepted", 32'(accepted), 32'd2);
        check("halt_delivered", 32'(delivered), 32'd2);
        check("halt_req_valid", 32'(imem_req_valid), 32'h0);

        // Asynchronous reset mid-flight, then restart from RESET_PC.
        fetch_en = 1'b1;
        wait_mq(2, 20, "mid_inflight");
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        mq.delete();
        sb.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        delivered = 0;
        accepted  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_stream(RESET_PC, 64);
        run_until_delivered(3, 30, "restart_out");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
